mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter: N, default 16, bfloat16 word width.
REQ-002 Parameter: DEPTH, default 4, product buffer depth and multiplier credit limit.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_start  input  1  start a dot-product; sampled in IDLE only.
REQ-006 len  input  8  element count, captured on accepted op_start.
REQ-007 in_valid / in_ready  input / output  1 / 1  operand-pair handshake; transfer when both are high.
REQ-008 a_in, b_in  input  N  operand pair.
REQ-009 mul_a, mul_b, mul_start  output  N, N, 1  pipelined multiplier issue port.
REQ-010 mul_finish, mul_result  input  1, N  multiplier completion, in order.
REQ-011 add_a, add_b, add_start  output  N, N, 1  pipelined adder issue port.
REQ-012 add_finish, add_result  input  1, N  adder completion.
REQ-013 busy  output  1  high in RUN.
REQ-014 op_finish  output  1  one-cycle pulse when result becomes valid.
REQ-015 result  output  N  final accumulated sum.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on op_start with len!=0.
- IDLE->DONE on op_start with len==0.
- RUN->DONE when added==len.
- DONE->IDLE unconditionally after 1 cycle.
REQ-017 On accepted op_start: acc<=0x0000; issued, inflight, added and buffer count cleared.
REQ-018 in_ready = RUN && issued<len && (inflight+count)<DEPTH; combinational.
REQ-019 Transfer: mul_start=1 same cycle, mul_a=a_in, mul_b=b_in, issued++, inflight++.
REQ-020 mul_finish pushes mul_result into product FIFO, inflight--; a simultaneous issue leaves inflight unchanged.
REQ-021 Credit rule guarantees no FIFO overflow; a push arriving with the FIFO full is a design error and is flagged by a simulation assertion.
REQ-022 Adder issue: when add_pending==0 and FIFO non-empty in RUN -> add_start=1, add_a=acc, add_b=FIFO head, pop, add_pending<=1.
REQ-023 On add_finish: acc<=add_result, added++, add_pending<=0; the next add_start occurs no earlier than the following cycle.
REQ-024 Simultaneous push and pop on an empty FIFO: the pushed entry is not visible until the next cycle.
REQ-025 In DONE: result<=acc (post-processed per REQ-031), op_finish=1 for exactly one cycle; result holds until the next accepted op_start completes.
REQ-026 op_start in RUN or DONE is ignored; mul_finish/add_finish in IDLE are ignored.
REQ-027 mul_start and add_start are single-cycle pulses; all port outputs are 0 when not issuing.

Reset
REQ-028 rst_n low: state=IDLE; acc, result, counters, FIFO pointers, add_pending = 0; in_ready, busy, op_finish, mul_start, add_start = 0.
REQ-029 Reset mid-operation aborts without op_finish; results from stale in-flight operations arriving after reset release are ignored.

Configuration
REQ-030 Macro MAC_SEQUENCER_RELU_EN selects output ReLU.
REQ-031 Defined: if acc[N-1]==1, result=0x0000, else result=acc. Undefined: result=acc unmodified, including negative values.

Verification
REQ-032 len=2, pairs (1.0,1.0),(2.0,2.0) = (0x3F80,0x3F80),(0x4000,0x4000), stub latencies 3/3 -> result 0x40A0, op_finish exactly once.
REQ-033 len=0 -> op_finish 1 cycle after op_start, result 0x0000, no mul_start or add_start.
REQ-034 len=8, all 0x3F80 pairs, in_valid held high, multiplier latency 6 -> in_ready drops once 4 outstanding, no FIFO overflow, result 0x4100.
REQ-035 len=1, (0x3F80,0xC000) -> result 0xC000 without macro; 0x0000 with MAC_SEQUENCER_RELU_EN.
REQ-036 rst_n low after 3 of 8 transfers -> all outputs at reset values, no op_finish; a new len=1 (0x4040,0x3F80) op -> result 0x4040.
REQ-037 op_start pulsed during RUN of a len=4 op -> ignored, single op_finish, correct sum.

Source files
------------

// File: rtl/mac_sequencer_if.sv
// Port bundle for mac_sequencer: operand stream, op control, and the issue/completion
// ports of the external pipelined bfloat16 multiplier and adder.
interface mac_sequencer_if #(
    parameter int unsigned N = 16
);
    logic         op_start;
    logic [7:0]   len;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [N-1:0] mul_a;
    logic [N-1:0] mul_b;
    logic         mul_start;
    logic         mul_finish;
    logic [N-1:0] mul_result;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_start;
    logic         add_finish;
    logic [N-1:0] add_result;
    logic         busy;
    logic         op_finish;
    logic [N-1:0] result;

    modport master (
        output op_start, len, in_valid, a_in, b_in, mul_finish, mul_result,
               add_finish, add_result,
        input  in_ready, mul_a, mul_b, mul_start, add_a, add_b, add_start,
               busy, op_finish, result
    );

    modport slave (
        input  op_start, len, in_valid, a_in, b_in, mul_finish, mul_result,
               add_finish, add_result,
        output in_ready, mul_a, mul_b, mul_start, add_a, add_b, add_start,
               busy, op_finish, result
    );
endinterface

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams operand pairs into a pipelined multiplier, buffers products,
// and accumulates them serially through a pipelined adder. MAC_SEQUENCER_RELU_EN clamps
// negative final results to zero.
module mac_sequencer #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    mac_sequencer_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [7:0]    len_q;
    logic [7:0]    issued_q;
    logic [7:0]    added_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [N-1:0]  acc_q;
    logic [N-1:0]  result_q;
    logic          op_finish_q;
    logic          add_pending_q;
    logic [N-1:0]  mem_q [DEPTH];

    logic run;
    logic credit_ok;
    logic in_ready;
    logic xfer;
    logic push;
    logic pop;
    logic add_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [N-1:0] post_proc(input logic [N-1:0] x);
`ifdef MAC_SEQUENCER_RELU_EN
        return x[N-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Products in flight plus products buffered may never exceed the buffer depth,
    // so every completion always finds a free slot.
    always_comb begin
        run       = (state_q == StRun);
        credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH);
        in_ready  = run && (issued_q < len_q) && credit_ok;
        xfer      = in_ready && bus.in_valid;
        // A completion with nothing outstanding is stale (from before a reset) and dropped.
        push      = run && bus.mul_finish && (inflight_q != '0);
        pop       = run && !add_pending_q && (count_q != '0);
        add_done  = run && bus.add_finish && add_pending_q;
    end

    assign bus.in_ready  = in_ready;
    assign bus.mul_start = xfer;
    assign bus.mul_a     = xfer ? bus.a_in : '0;
    assign bus.mul_b     = xfer ? bus.b_in : '0;
    assign bus.add_start = pop;
    assign bus.add_a     = pop ? acc_q : '0;
    assign bus.add_b     = pop ? mem_q[rptr_q] : '0;
    assign bus.busy      = run;
    assign bus.op_finish = op_finish_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.mul_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            len_q         <= '0;
            issued_q      <= '0;
            added_q       <= '0;
            inflight_q    <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            acc_q         <= '0;
            result_q      <= '0;
            op_finish_q   <= 1'b0;
            add_pending_q <= 1'b0;
        end else begin
            op_finish_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.op_start) begin
                        len_q         <= bus.len;
                        acc_q         <= '0;
                        issued_q      <= '0;
                        added_q       <= '0;
                        inflight_q    <= '0;
                        count_q       <= '0;
                        wptr_q        <= '0;
                        rptr_q        <= '0;
                        add_pending_q <= 1'b0;
                        if (bus.len == 8'd0) begin
                            state_q     <= StDone;
                            op_finish_q <= 1'b1;
                            result_q    <= post_proc('0);
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (xfer) begin
                        issued_q <= issued_q + 8'd1;
                    end
                    case ({xfer, push})
                        2'b10:   inflight_q <= inflight_q + CW'(1);
                        2'b01:   inflight_q <= inflight_q - CW'(1);
                        default: ;
                    endcase
                    case ({push, pop})
                        2'b10:   count_q <= count_q + CW'(1);
                        2'b01:   count_q <= count_q - CW'(1);
                        default: ;
                    endcase
                    if (push) begin
                        wptr_q <= ptr_inc(wptr_q);
                    end
                    if (pop) begin
                        rptr_q        <= ptr_inc(rptr_q);
                        add_pending_q <= 1'b1;
                    end
                    // pop needs !add_pending and add_done needs add_pending: never both.
                    if (add_done) begin
                        acc_q         <= bus.add_result;
                        added_q       <= added_q + 8'd1;
                        add_pending_q <= 1'b0;
                        if (added_q + 8'd1 == len_q) begin
                            state_q     <= StDone;
                            op_finish_q <= 1'b1;
                            result_q    <= post_proc(bus.add_result);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q != CW'(DEPTH)));

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized bench for mac_sequencer with multiplier/adder stubs and a transaction-level
// model of credits, product ordering and accumulation.
module tb_mac_sequencer;

    localparam int unsigned N     = 16;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_sequencer_if #(.N(N)) bus ();

    mac_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_vec = 0;
    int n_miss = 0;

    // Stimulus / stub configuration
    logic [15:0] opa_q[$];
    logic [15:0] opb_q[$];
    bit          hold_valid = 1'b0;
    int          mul_lat = 3;
    int          add_lat = 3;
    int          cyc = 0;
    logic [15:0] mq_val[$];
    int          mq_due[$];
    logic [15:0] aq_val[$];
    int          aq_due[$];
    logic [15:0] vals[7];

    // Transaction-level model
    bit          m_busy = 1'b0;
    bit          m_fin_due = 1'b0;
    bit          m_pend = 1'b0;
    int          m_len = 0;
    int          m_issued = 0;
    int          m_pops = 0;
    int          m_added = 0;
    logic [15:0] m_acc = '0;
    logic [15:0] m_result = '0;
    logic [15:0] m_prod[$];
    int          fin_count = 0;
    bit          saw_throttle = 1'b0;
    bit          exp_ready, exp_mul, exp_add, fin_now;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic real bf2r(input logic [15:0] x);
        real m;
        if (x[14:0] == 15'd0) return 0.0;
        m = (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** (real'(x[14:7]) - 127.0));
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] b;
        int          e;
        if (r == 0.0) return 16'h0000;
        b = $realtobits(r);
        e = int'(b[62:52]) - 896;
        return {b[63], e[7:0], b[51:45]};
    endfunction

    function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) * bf2r(b));
    endfunction

    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef MAC_SEQUENCER_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    // Per-cycle driver, stubs, model and compare. Inputs change on the falling edge, outputs
    // are compared 1 time unit later, and the model advances as of the next rising edge.
    initial begin
        bus.in_valid   = 1'b0;
        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.mul_finish = 1'b0;
        bus.mul_result = '0;
        bus.add_finish = 1'b0;
        bus.add_result = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                bus.mul_finish = 1'b1;
                bus.mul_result = mq_val.pop_front();
                void'(mq_due.pop_front());
            end else begin
                bus.mul_finish = 1'b0;
                bus.mul_result = 16'($urandom);
            end
            if (aq_due.size() > 0 && aq_due[0] <= cyc) begin
                bus.add_finish = 1'b1;
                bus.add_result = aq_val.pop_front();
                void'(aq_due.pop_front());
            end else begin
                bus.add_finish = 1'b0;
                bus.add_result = 16'($urandom);
            end
            if (opa_q.size() > 0) begin
                bus.in_valid = hold_valid || ($urandom_range(0, 3) != 0);
                bus.a_in     = opa_q[0];
                bus.b_in     = opb_q[0];
            end else begin
                bus.in_valid = m_busy ? 1'b0 : 1'($urandom_range(0, 1));
                bus.a_in     = 16'($urandom);
                bus.b_in     = 16'($urandom);
            end
            #1;
            if (!rst_n) begin
                m_busy = 1'b0; m_fin_due = 1'b0; m_pend = 1'b0;
                m_issued = 0; m_pops = 0; m_added = 0; m_len = 0;
                m_acc = '0; m_result = '0; m_prod.delete();
            end
            // Credits outstanding = products issued but not yet handed to the adder.
            exp_ready = m_busy && (m_issued < m_len) && ((m_issued - m_pops) < int'(DEPTH));
            exp_mul   = exp_ready && bus.in_valid;
            exp_add   = m_busy && !m_pend && (m_prod.size() > 0);
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check("mul_start", 32'(bus.mul_start), 32'(exp_mul));
            check("mul_a", 32'(bus.mul_a), exp_mul ? 32'(bus.a_in) : 32'h0);
            check("mul_b", 32'(bus.mul_b), exp_mul ? 32'(bus.b_in) : 32'h0);
            check("add_start", 32'(bus.add_start), 32'(exp_add));
            check("add_a", 32'(bus.add_a), exp_add ? 32'(m_acc) : 32'h0);
            check("add_b", 32'(bus.add_b), exp_add ? 32'(m_prod[0]) : 32'h0);
            check("op_finish", 32'(bus.op_finish), 32'(m_fin_due));
            check("result", 32'(bus.result), 32'(m_result));
            if (bus.op_finish) fin_count++;
            if (m_busy && bus.in_valid && !exp_ready && m_issued < m_len) saw_throttle = 1'b1;
            if (rst_n) begin
                fin_now   = m_fin_due;
                m_fin_due = 1'b0;
                if (!m_busy && !fin_now && bus.op_start) begin
                    m_len = int'(bus.len);
                    m_issued = 0; m_pops = 0; m_added = 0; m_pend = 1'b0;
                    m_acc = '0; m_prod.delete();
                    if (m_len == 0) begin
                        m_fin_due = 1'b1;
                        m_result  = relu(16'h0000);
                    end else begin
                        m_busy = 1'b1;
                    end
                end else if (m_busy) begin
                    if (exp_mul) m_issued++;
                    if (exp_add) begin
                        m_pops++;
                        m_pend = 1'b1;
                        void'(m_prod.pop_front());
                    end
                    if (bus.mul_finish) m_prod.push_back(bus.mul_result);
                    if (bus.add_finish && m_pend) begin
                        m_acc = bus.add_result;
                        m_added++;
                        m_pend = 1'b0;
                        if (m_added == m_len) begin
                            m_busy    = 1'b0;
                            m_fin_due = 1'b1;
                            m_result  = relu(m_acc);
                        end
                    end
                end
            end
            if (bus.mul_start) begin
                mq_val.push_back(bf_mul(bus.mul_a, bus.mul_b));
                mq_due.push_back(cyc + mul_lat);
                if (opa_q.size() > 0) begin
                    void'(opa_q.pop_front());
                    void'(opb_q.pop_front());
                end
            end
            if (bus.add_start) begin
                aq_val.push_back(bf_add(bus.add_a, bus.add_b));
                aq_due.push_back(cyc + add_lat);
            end
        end
    end

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        opa_q.push_back(a);
        opb_q.push_back(b);
    endtask

    task automatic run_op(input string name, input int ln, input bit poke, input bit use_pin,
                          input logic [15:0] pin);
        logic [15:0] acc;
        logic [15:0] exp_res;
        int          f0;
        int          c;
        acc = 16'h0000;
        for (int i = 0; i < ln && i < opa_q.size(); i++) begin
            acc = bf_add(acc, bf_mul(opa_q[i], opb_q[i]));
        end
        exp_res = relu(acc);
        f0 = fin_count;
        @(posedge clk); #2;
        bus.op_start = 1'b1;
        bus.len      = 8'(ln);
        @(posedge clk); #2;
        bus.op_start = 1'b0;
        bus.len      = 8'($urandom);
        if (poke) begin
            repeat (2) @(posedge clk);
            #2;
            bus.op_start = 1'b1;
            bus.len      = 8'd7;
            @(posedge clk); #2;
            bus.op_start = 1'b0;
        end
        c = 0;
        while (fin_count == f0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        check({name, "_done"}, 32'(fin_count != f0), 32'h1);
        #2;
        check({name, "_result"}, 32'(bus.result), 32'(exp_res));
        if (use_pin) check({name, "_pin"}, 32'(bus.result), 32'(pin));
        repeat (4) @(posedge clk);
        check({name, "_one_finish"}, 32'(fin_count - f0), 32'h1);
    endtask

    initial begin
        logic [15:0] pin35;
        int          ln;
        int          f0;
        int          c;
        bus.op_start = 1'b0;
        bus.len      = '0;
        vals[0] = 16'h3F80; vals[1] = 16'h4000; vals[2] = 16'h4040; vals[3] = 16'hBF80;
        vals[4] = 16'hC000; vals[5] = 16'h3F00; vals[6] = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_result", 32'(bus.result), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two-element sum of squares: 1 + 4 = 5.0
        mul_lat = 3; add_lat = 3; hold_valid = 1'b0;
        load(16'h3F80, 16'h3F80);
        load(16'h4000, 16'h4000);
        run_op("len2", 2, 1'b0, 1'b1, 16'h40A0);

        // Empty vector completes immediately with zero and no issues.
        run_op("len0", 0, 1'b0, 1'b1, 16'h0000);

        // Long multiplier latency exercises the credit limit.
        mul_lat = 6; add_lat = 2; hold_valid = 1'b1; saw_throttle = 1'b0;
        for (int i = 0; i < 8; i++) load(16'h3F80, 16'h3F80);
        run_op("len8", 8, 1'b0, 1'b1, 16'h4100);
        check("credit_throttle", 32'(saw_throttle), 32'h1);

        // Negative result: passed through or clamped.
        mul_lat = 2; add_lat = 1; hold_valid = 1'b0;
`ifdef MAC_SEQUENCER_RELU_EN
        pin35 = 16'h0000;
`else
        pin35 = 16'hC000;
`endif
        load(16'h3F80, 16'hC000);
        run_op("neg", 1, 1'b0, 1'b1, pin35);

        // op_start during RUN is ignored: 1+2+3+1 = 7.0
        mul_lat = 3; add_lat = 2;
        load(16'h3F80, 16'h3F80);
        load(16'h4000, 16'h3F80);
        load(16'h4040, 16'h3F80);
        load(16'hBF80, 16'hBF80);
        run_op("poke", 4, 1'b1, 1'b1, 16'h40E0);

        // Abort after three of eight transfers.
        mul_lat = 5; add_lat = 3; hold_valid = 1'b1;
        for (int i = 0; i < 3; i++) load(16'h4000, 16'h3F80);
        f0 = fin_count;
        @(posedge clk); #2;
        bus.op_start = 1'b1;
        bus.len      = 8'd8;
        @(posedge clk); #2;
        bus.op_start = 1'b0;
        c = 0;
        while (m_issued < 3 && c < 200) begin
            @(posedge clk);
            c++;
        end
        check("abort_issued3", 32'(m_issued), 32'd3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_mul_start", 32'(bus.mul_start), 32'h0);
        check("abort_add_start", 32'(bus.add_start), 32'h0);
        check("abort_result", 32'(bus.result), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("abort_no_finish", 32'(fin_count - f0), 32'h0);
        hold_valid = 1'b0;
        load(16'h4040, 16'h3F80);
        run_op("after_abort", 1, 1'b0, 1'b1, 16'h4040);

        // Randomized operations
        for (int t = 0; t < 16; t++) begin
            ln = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            mul_lat = int'($urandom_range(1, 7));
            add_lat = int'($urandom_range(1, 4));
            hold_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < ln; i++) begin
                load(vals[$urandom_range(0, 6)], vals[$urandom_range(0, 6)]);
            end
            run_op("rand", ln, (ln >= 3) && ($urandom_range(0, 2) == 0), 1'b0, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
